// File: rtl/mmio_pkg.sv
// mmio_pkg: address-map constants, status bit positions and decode types shared by the MMIO block.
// Provides default-parameter constants plus helper functions that recompute the map for other
// RAM/screen sizes, so the top level and the bench always agree on where each region lives.
package mmio_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KDATA,
        REG_KSTAT,
        REG_NONE
    } region_t;

    function automatic int screen_base(input int ram_aw);
        return 1 << ram_aw;
    endfunction

    function automatic int kbd_data_addr(input int ram_aw, input int screen_aw);
        return (1 << ram_aw) + (1 << screen_aw);
    endfunction

    function automatic int kbd_stat_addr(input int ram_aw, input int screen_aw);
        return kbd_data_addr(ram_aw, screen_aw) + 1;
    endfunction

    function automatic int stat_ovf_bit(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int kbd_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int SCREEN_BASE = screen_base(14);
    localparam int KBD_DATA    = kbd_data_addr(14, 13);
    localparam int KBD_STAT    = kbd_stat_addr(14, 13);

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: keyboard key FIFO, DEPTH entries (power of two) with occupancy count.
// Ports: clock/reset (async active-low), push/din enqueue, pop dequeues, dout = current head,
// count = occupancy, full/empty flags. Push while full and pop while empty are ignored.
module kbd_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = r_count == CW'(DEPTH);
    assign empty  = r_count == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd];
    assign count  = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/mmio_memory.sv
// mmio_memory: CPU-facing memory map of data RAM, screen RAM and a keyboard FIFO with status.
// Ports: clock/reset (async active-low); address/in/load/read CPU bus; out/out_valid registered
// read result one cycle after read; kbd_valid/kbd_key/kbd_ready keyboard handshake.
// Reads sample storage before the same-edge write lands, giving read-old-data on collisions.
module mmio_memory
    import mmio_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int RAM_AW    = 14,
    parameter int SCREEN_AW = 13,
    parameter int KBD_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic              read,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_key,
    output logic              kbd_ready
);
    localparam logic [31:0] SB  = 32'(screen_base(RAM_AW));
    localparam logic [31:0] KD  = 32'(kbd_data_addr(RAM_AW, SCREEN_AW));
    localparam logic [31:0] KS  = 32'(kbd_stat_addr(RAM_AW, SCREEN_AW));
    localparam int          OVF = stat_ovf_bit(DATA_W);
    localparam int          KCW = kbd_count_w(KBD_DEPTH);

    logic [DATA_W-1:0]    r_ram    [2**RAM_AW];
    logic [DATA_W-1:0]    r_screen [2**SCREEN_AW];
    logic [DATA_W-1:0]    r_out;
    logic                 r_out_valid;
    logic                 r_ovf;
    logic [31:0]          w_addr;
    region_t              w_region;
    logic [RAM_AW-1:0]    w_ram_idx;
    logic [SCREEN_AW-1:0] w_scr_idx;
    logic [DATA_W-1:0]    w_head;
    logic [DATA_W-1:0]    w_stat;
    logic [DATA_W-1:0]    w_rdata;
    logic [KCW-1:0]       w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    assign w_addr    = 32'(address);
    assign w_ram_idx = RAM_AW'(w_addr);
    assign w_scr_idx = SCREEN_AW'(w_addr - SB);
    assign kbd_ready = !w_full;
    assign w_push    = kbd_valid && kbd_ready;
    assign w_pop     = read && w_region == REG_KDATA && !w_empty;
    assign w_stat    = DATA_W'(w_count) | (DATA_W'(r_ovf) << OVF);
    assign out       = r_out;
    assign out_valid = r_out_valid;

    always_comb begin
        w_region = w_addr < SB  ? REG_RAM    :
                   w_addr < KD  ? REG_SCREEN :
                   w_addr == KD ? REG_KDATA  :
                   w_addr == KS ? REG_KSTAT  : REG_NONE;
        w_rdata  = w_region == REG_RAM    ? r_ram[w_ram_idx]    :
                   w_region == REG_SCREEN ? r_screen[w_scr_idx] :
                   w_region == REG_KDATA  ? (w_empty ? '0 : w_head) :
                   w_region == REG_KSTAT  ? w_stat : '0;
    end

    kbd_fifo #(
        .W     (DATA_W),
        .DEPTH (KBD_DEPTH),
        .CW    (KCW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (kbd_key),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clock) begin
        if (load && w_region == REG_RAM) r_ram[w_ram_idx] <= in;
        if (load && w_region == REG_SCREEN) r_screen[w_scr_idx] <= in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= read;
            if (read) r_out <= w_rdata;
        end
    end

    // A dropped key sets overflow and takes priority over a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_ovf <= 1'b0;
        else if (kbd_valid && !kbd_ready) r_ovf <= 1'b1;
        else if (load && w_region == REG_KSTAT) r_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_mmio_memory.sv
// tb_mmio_memory: directed self-checking bench with a scoreboard queue of expected read data.
module tb_mmio_memory;
    import mmio_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] address = '0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic        read = 1'b0;
    logic [15:0] out;
    logic        out_valid;
    logic        kbd_valid = 1'b0;
    logic [15:0] kbd_key = '0;
    logic        kbd_ready;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] sb_q[$];

    localparam logic [14:0] A_KD = 15'(KBD_DATA);
    localparam logic [14:0] A_KS = 15'(KBD_STAT);

    mmio_memory dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .in        (in),
        .load      (load),
        .read      (read),
        .out       (out),
        .out_valid (out_valid),
        .kbd_valid (kbd_valid),
        .kbd_key   (kbd_key),
        .kbd_ready (kbd_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards compare against the scoreboard if a read was issued.
    task automatic cyc(input string tag);
        logic was_rd;
        logic [15:0] e;
        was_rd = read;
        @(posedge clock);
        #1;
        if (was_rd) begin
            chk({tag, ".valid"}, 16'(out_valid), 16'd1);
            e = sb_q.size() > 0 ? sb_q.pop_front() : 16'hxxxx;
            chk({tag, ".data"}, out, e);
        end else begin
            chk({tag, ".idle"}, 16'(out_valid), 16'd0);
        end
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        address = a;
        in = d;
        load = 1'b1;
        cyc("wr");
        load = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] e);
        address = a;
        read = 1'b1;
        sb_q.push_back(e);
        cyc(tag);
        read = 1'b0;
    endtask

    task automatic key(input logic [15:0] k);
        kbd_key = k;
        kbd_valid = 1'b1;
        @(posedge clock);
        #1;
        kbd_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst.out", out, 16'h0000);
        chk("rst.valid", 16'(out_valid), 16'd0);
        chk("rst.ready", 16'(kbd_ready), 16'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        wr(15'h0005, 16'h1234);
        rd("ram", 15'h0005, 16'h1234);
        cyc("hold");
        chk("hold.out", out, 16'h1234);

        wr(15'h3FFF, 16'h5A5A);
        wr(15'h4000, 16'hBEEF);
        rd("scr", 15'h4000, 16'hBEEF);
        rd("ram_top", 15'h3FFF, 16'h5A5A);
        wr(15'h5FFF, 16'hC0DE);
        rd("scr_top", 15'h5FFF, 16'hC0DE);

        key(16'h0041);
        key(16'h0042);
        rd("stat2", A_KS, 16'h0002);
        rd("pop41", A_KD, 16'h0041);
        rd("pop42", A_KD, 16'h0042);
        rd("pop_empty", A_KD, 16'h0000);

        for (int i = 1; i <= 5; i++) begin
            key(16'(i));
            chk($sformatf("ready%0d", i), 16'(kbd_ready), 16'(i < 4));
        end
        rd("stat_ovf", A_KS, 16'h8004);
        wr(A_KS, 16'h0000);
        rd("stat_clr", A_KS, 16'h0004);
        for (int i = 1; i <= 4; i++) rd($sformatf("drain%0d", i), A_KD, 16'(i));
        rd("drain_empty", A_KD, 16'h0000);

        for (int i = 0; i < 4; i++) key(16'h0010 + 16'(i));
        kbd_key = 16'h0014;
        kbd_valid = 1'b1;
        chk("full_ready", 16'(kbd_ready), 16'd0);
        rd("full_pushpop", A_KD, 16'h0010);
        kbd_valid = 1'b0;
        rd("stat_full_pp", A_KS, 16'h8003);
        wr(A_KS, 16'h0000);
        kbd_key = 16'h0015;
        kbd_valid = 1'b1;
        rd("mid_pushpop", A_KD, 16'h0011);
        kbd_valid = 1'b0;
        rd("stat_mid_pp", A_KS, 16'h0003);
        key(16'h0016);
        kbd_key = 16'h0017;
        kbd_valid = 1'b1;
        wr(A_KS, 16'h0000);
        kbd_valid = 1'b0;
        rd("ovf_wins", A_KS, 16'h8004);
        rd("wrap1", A_KD, 16'h0012);
        rd("wrap2", A_KD, 16'h0013);
        rd("wrap3", A_KD, 16'h0015);
        rd("wrap4", A_KD, 16'h0016);
        wr(A_KS, 16'h0000);
        kbd_key = 16'h0077;
        kbd_valid = 1'b1;
        rd("empty_pushpop", A_KD, 16'h0000);
        kbd_valid = 1'b0;
        rd("stat_empty_pp", A_KS, 16'h0001);
        rd("pop77", A_KD, 16'h0077);

        address = 15'h0005;
        in = 16'hAAAA;
        load = 1'b1;
        read = 1'b1;
        sb_q.push_back(16'h1234);
        cyc("rbw_old");
        load = 1'b0;
        read = 1'b0;
        rd("rbw_new", 15'h0005, 16'hAAAA);

        rd("unmapped", 15'h7000, 16'h0000);
        wr(15'h7000, 16'hFFFF);
        wr(A_KD, 16'hFFFF);
        rd("um_ram", 15'h0005, 16'hAAAA);
        rd("um_ram_top", 15'h3FFF, 16'h5A5A);
        rd("um_scr", 15'h4000, 16'hBEEF);
        rd("um_scr_top", 15'h5FFF, 16'hC0DE);
        rd("um_stat", A_KS, 16'h0000);
        rd("um_7000", 15'h7000, 16'h0000);

        key(16'h0001);
        key(16'h0002);
        key(16'h0003);
        rd("pre_rst_stat", A_KS, 16'h0003);
        address = A_KD;
        read = 1'b1;
        @(posedge clock);
        #1;
        read = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst.out", out, 16'h0000);
        chk("mid_rst.valid", 16'(out_valid), 16'd0);
        chk("mid_rst.ready", 16'(kbd_ready), 16'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        rd("post_rst_stat", A_KS, 16'h0000);
        chk("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
